// File: rtl/seq_mult4.sv
`default_nettype none
// ============================================================================
// Module : seq_mult4
// Free-running unsigned radix-2 shift-add multiplier, one multiplier bit per
// clock; a new registered product every WIDTH+2 cycles, qualified by done.
// Rev    : 1.0
// ============================================================================
module seq_mult4 #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     operand_a,
   input  logic [WIDTH-1:0]     operand_b,
   output logic [2*WIDTH-1:0]   product,
   output logic                 done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_product;
   logic [WIDTH-1:0]     r_mplier;
   logic [CW-1:0]        r_cnt;
   logic                 r_done;
   logic [2*WIDTH-1:0]   w_acc_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = CALC;
         CALC:    if (r_cnt == c_CNT_LAST) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Full 2*WIDTH-bit add: the shifted multiplicand never drops bits.
   assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_product <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_mcand  <= {{WIDTH{1'b0}}, operand_a};
               r_mplier <= operand_b;
               r_acc    <= '0;
               r_cnt    <= '0;
            end
            CALC: begin
               r_acc    <= w_acc_nxt;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + c_CNT_ONE;
            end
            DONE: begin
               r_product <= r_acc;
               r_done    <= 1'b1;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign product = r_product;
   assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult4.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_mult4
// Scoreboard bench for seq_mult4: stimulus pushes expected products, a
// monitor pops and compares on every done pulse.
// Rev    : 1.0
// ============================================================================
module tb_seq_mult4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] a = 4'd0;
   logic [3:0] b = 4'd0;
   logic [7:0] product;
   logic       done;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q[$];

   seq_mult4 #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .operand_a (a),
      .operand_b (b),
      .product   (product),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Entered just after a negedge that precedes a capture edge; returns at
   // the equivalent point one period later.
   task automatic apply(input logic [3:0] ta, input logic [3:0] tb_v, input logic [7:0] e);
      a = ta;
      b = tb_v;
      exp_q.push_back(e);
      repeat (6) @(negedge clk);
      #1;
   endtask

   initial begin : monitor
      logic [7:0] held;
      int         cyc;
      int         last;
      held = '0;
      cyc  = 0;
      last = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            held = '0;
            cyc  = 0;
            last = 0;
         end else begin
            cyc++;
            if (done) begin
               check("done_spacing", cyc - last, 6);
               last = cyc;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: product %0d with empty queue at %0t", product, $time);
               end else begin
                  held = exp_q.pop_front();
                  check("product", int'(product), int'(held));
               end
            end else begin
               check("product_hold", int'(product), int'(held));
            end
         end
      end
   end

   logic [3:0] dir_a [8] = '{4'd12, 4'd2, 4'd10, 4'd15, 4'd0, 4'd9, 4'd1, 4'd6};
   logic [3:0] dir_b [8] = '{4'd3, 4'd15, 4'd5, 4'd15, 4'd9, 4'd0, 4'd13, 4'd7};
   logic [7:0] dir_e [8] = '{8'd36, 8'd30, 8'd50, 8'd225, 8'd0, 8'd0, 8'd13, 8'd42};

   initial begin : stimulus
      a   = 4'd5;
      b   = 4'd3;
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("reset_product", int'(product), 0);
         check("reset_done", int'(done), 0);
      end
      #1 rst = 1'b1;
      apply(4'd5, 4'd3, 8'd15);

      for (int i = 0; i < 8; i++) begin
         apply(dir_a[i], dir_b[i], dir_e[i]);
      end

      // Operands change two cycles into CALC: in-flight result unaffected.
      a = 4'd7;
      b = 4'd6;
      exp_q.push_back(8'd42);
      @(posedge clk);
      @(posedge clk);
      #1;
      a = 4'd3;
      b = 4'd3;
      repeat (5) @(negedge clk);
      #1;
      apply(4'd3, 4'd3, 8'd9);

      // Asynchronous reset between edges while CALC is in progress.
      a = 4'd11;
      b = 4'd11;
      exp_q.push_back(8'd121);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_product", int'(product), 0);
      check("abort_done", int'(done), 0);
      void'(exp_q.pop_back());
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      apply(4'd11, 4'd11, 8'd121);

      for (int i = 0; i < 256; i++) begin
         logic [3:0] ea;
         logic [3:0] eb;
         logic [7:0] ee;
         ea = 4'(i >> 4);
         eb = 4'(i);
         ee = 8'((i >> 4) * (i & 15));
         apply(ea, eb, ee);
      end

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      check("pending_results", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
